vid_ram_gen: RTL and testbench
==============================

Name: vid_ram_gen

Overview:
Parametrised single-clock video RAM; successor to the fixed 6 KB x 8 frame buffer. Port A is a CPU-side request/acknowledge read/write port. Port B is a video-side read port with fixed latency and valid flag. A built-in clear engine fills the whole array with a constant, so software need not loop over the frame buffer.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 13, address width of both ports
DEPTH, 6144, number of words implemented; must be <= 2^ADDR_WIDTH
MEM_INIT_FILE, "", hex init file; empty string means no $readmemh
FILL_VALUE, 0, word written by the clear engine (DATA_WIDTH bits)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
a_req  input  1  port A request, held until a_ack
a_we  input  1  port A write (1) / read (0)
a_addr  input  ADDR_WIDTH  port A address
a_din  input  DATA_WIDTH  port A write data
a_ack  output  1  one-cycle acknowledge
a_dout  output  DATA_WIDTH  port A read data, valid when a_ack=1 for a read
b_en  input  1  port B read enable
b_addr  input  ADDR_WIDTH  port B address
b_dout  output  DATA_WIDTH  port B read data
b_valid  output  1  b_dout updated this cycle
clr_start  input  1  start clear-engine pulse
clr_busy  output  1  clear engine is writing
clr_done  output  1  one-cycle pulse after the last clear write

Behaviour:
- Reset: a_ack, a_dout, b_dout, b_valid, clr_busy and clr_done are all 0; FSM goes to IDLE. Memory contents are untouched by reset.
- Port A acceptance: accepted on an edge where a_req=1, FSM=IDLE, clr_start=0 and a_ack=0. Acceptance is not allowed on the ack cycle, so a held request is never double-serviced.
  - Write commits at the acceptance edge.
  - a_ack=1 for exactly the next cycle.
  - Read: a_dout carries the data for the accepted address in the a_ack cycle and holds its value otherwise.
- Port A out of range (a_addr >= DEPTH): write discarded, read returns 0, still acked.
- Port B: b_en=1 at edge N gives b_dout = mem[b_addr] and b_valid=1 in cycle N+1.
  - b_en=0: b_valid=0 and b_dout holds its value.
  - Out-of-range address returns 0.
  - Port B is never stalled, including during a clear.
- Same-cycle port A write and port B read to the same address: B returns the old data (see the optional feature).
- Clear FSM has three states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start=1; clr_ptr <= 0.
  - CLEAR writes FILL_VALUE to mem[clr_ptr] on each edge, then increments clr_ptr. After the write at DEPTH-1 it goes to DONE.
  - clr_busy=1 for every CLEAR cycle, exactly DEPTH cycles.
  - DONE lasts one cycle with clr_done=1, then returns to IDLE.
  - clr_start outside IDLE is ignored.
- Port A stalls while FSM != IDLE (a_ack=0; master keeps a_req). If clr_start and a_req arrive together, the clear wins and port A is serviced on the first IDLE cycle after DONE.
- Reset mid-clear aborts immediately: partial fill remains and no clr_done is generated.
- clr_ptr is ADDR_WIDTH bits wide and is compared against DEPTH-1, so there is no wrap past DEPTH.

Optional Feature:
VID_RAM_GEN_BYPASS_EN
- Defined: if a port A write is accepted at the same edge as a port B read of the same in-range address, b_dout returns the new a_din (write-first). The same applies to a clear-engine write colliding with a port B read, which returns FILL_VALUE.
- Undefined: port B returns the old contents (read-first) and no forwarding logic is built.

Test Plan:
1. Reset, then port A write 0x5A to 0x0100, then port A read 0x0100 -> a_ack exactly 1 cycle after each acceptance; a_dout=0x5A in the read ack cycle.
2. Port B b_en=1 at 0x0100 for 3 cycles -> b_valid=1 and b_dout=0x5A from the second cycle on. Repeat with b_addr=6144 -> b_dout=0x00.
3. Write 0x11 to 0x0000 and simultaneously read 0x0000 on B (mem holds 0x22) -> b_dout=0x22 without the macro, 0x11 with it.
4. clr_start with FILL_VALUE=0x20 and DEPTH=6144 -> clr_busy high for 6144 cycles, then clr_done pulses once. B reads of 0x0000 and 0x17FF return 0x20. A write issued mid-clear is acked only after DONE and then lands.
5. Assert reset at clear cycle 100 -> clr_busy=0 next cycle and no clr_done. Address 99 holds 0x20; address 100 holds its old value.
6. Held a_req read for 4 cycles -> exactly two acceptances, each with a single-cycle a_ack and no back-to-back acks. clr_start pulsed during a clear -> ignored; busy length unchanged.

Source files
------------

// File: rtl/vid_ram_gen_if.sv
// vid_ram_gen_if: bundle of the CPU-side port A, the video-side port B and
// the clear-engine control/status lines of vid_ram_gen.
// master = the system driving requests; slave = the RAM itself.
interface vid_ram_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
);

  // Port A: request/acknowledge read/write port
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_dout;

  // Port B: fixed-latency video read port
  logic                  b_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;

  // Clear engine
  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output a_req, a_we, a_addr, a_din,
    input  a_ack, a_dout,
    output b_en, b_addr,
    input  b_dout, b_valid,
    output clr_start,
    input  clr_busy, clr_done
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    output a_ack, a_dout,
    input  b_en, b_addr,
    output b_dout, b_valid,
    input  clr_start,
    output clr_busy, clr_done
  );

endinterface : vid_ram_gen_if

// File: rtl/vid_ram_gen.sv
// vid_ram_gen: parametrised single-clock video RAM.
//  - Port A: CPU request/ack read/write, one-cycle ack, never double-serviced.
//  - Port B: video read, one cycle latency, never stalled.
//  - Clear engine: fills all DEPTH words with FILL_VALUE, one word per cycle.
// Optional build macro: VID_RAM_GEN_BYPASS_EN
//  - defined  : port B forwards a colliding same-edge write (write-first).
//  - undefined: port B returns the old contents (read-first), no forwarding.
module vid_ram_gen #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 13,
  parameter int                    DEPTH         = 6144,
  parameter string                 MEM_INIT_FILE = "",
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE    = '0
) (
  input  logic          clk,
  input  logic          reset,
  vid_ram_gen_if.slave  bus
);

  // Array index width; addresses at or above DEPTH never reach the array.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH widened by one bit so the range compare works when DEPTH == 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clr_state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  logic                  a_ack_q;
  logic [DATA_WIDTH-1:0] a_dout_q;
  logic [DATA_WIDTH-1:0] b_dout_q;
  logic                  b_valid_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic a_in_range;
  logic b_in_range;
  logic a_accept;

  assign a_in_range = ({1'b0, bus.a_addr} < DEPTH_W);
  assign b_in_range = ({1'b0, bus.b_addr} < DEPTH_W);

  // A request is taken only from IDLE, loses to a simultaneous clr_start, and
  // is blocked on its own ack cycle so a held a_req is not serviced twice.
  assign a_accept = !reset && bus.a_req && (state_q == ST_IDLE) &&
                    !bus.clr_start && !a_ack_q;

  // ---------------------------------------------------------------------------
  // Single write port shared by the clear engine and port A. They never
  // compete: port A is only accepted in IDLE, the engine only writes in CLEAR.
  // ---------------------------------------------------------------------------
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Select the write source for this edge; reset suppresses all writes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves a value unassigned (no latch).
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_q;
        wr_data = FILL_VALUE;
      end else if (a_accept && bus.a_we && a_in_range) begin
        wr_en   = 1'b1;
        wr_addr = bus.a_addr;
        wr_data = bus.a_din;
      end
    end
  end

  // Array write.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; a reset would prevent block
    // RAM mapping and contents must survive reset anyway.
    if (wr_en) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear-engine FSM
  // ---------------------------------------------------------------------------

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Clear FSM next state: start from IDLE, one word per CLEAR cycle, one DONE cycle.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_DONE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.clr_busy = (state_q == ST_CLEAR);
  assign bus.clr_done = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Port A response
  // ---------------------------------------------------------------------------

  // One-cycle ack per acceptance; read data captured at acceptance and held.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_ack_q  <= 1'b0;
      a_dout_q <= '0;
    end else begin
      a_ack_q <= a_accept;
      if (a_accept && !bus.a_we) begin
        a_dout_q <= a_in_range ? mem[bus.a_addr[IDX_W-1:0]] : '0;
      end
    end
  end

  assign bus.a_ack  = a_ack_q;
  assign bus.a_dout = a_dout_q;

  // ---------------------------------------------------------------------------
  // Port B read
  // ---------------------------------------------------------------------------

  // Video read: b_en at edge N gives data and valid in cycle N+1; data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid_q <= 1'b0;
      b_dout_q  <= '0;
    end else begin
      b_valid_q <= bus.b_en;
      if (bus.b_en) begin
        if (!b_in_range) begin
          b_dout_q <= '0;
`ifdef VID_RAM_GEN_BYPASS_EN
        end else if (wr_en && (wr_addr == bus.b_addr)) begin
          // Write-first: forward the word being written at this same edge.
          b_dout_q <= wr_data;
`endif
        end else begin
          b_dout_q <= mem[bus.b_addr[IDX_W-1:0]];
        end
      end
    end
  end

  assign bus.b_dout  = b_dout_q;
  assign bus.b_valid = b_valid_q;

endmodule : vid_ram_gen

// File: tb/tb_vid_ram_gen.sv
// tb_vid_ram_gen: randomized self-checking bench for vid_ram_gen.
// A behavioural model (word array plus a clear progress index) predicts every
// output each cycle; directed sequences cover the clear, reset-abort,
// collision and held-request cases.
module tb_vid_ram_gen;

  localparam int          DW    = 8;
  localparam int          AW    = 13;
  localparam int          DEPTH = 6144;
  localparam logic [7:0]  FILL  = 8'h20;
`ifdef VID_RAM_GEN_BYPASS_EN
  localparam bit          BYP   = 1'b1;
`else
  localparam bit          BYP   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vid_ram_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vid_ram_gen #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .MEM_INIT_FILE(""),
    .FILL_VALUE   (FILL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] m_mem [DEPTH];
  int         m_clr;        // -1 idle, 0..DEPTH-1 next word to clear, DEPTH done cycle
  bit         m_ack_prev;
  logic [7:0] m_a_dout;
  logic [7:0] m_b_dout;
  bit         m_accepted;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock: predict from the rules, clock the DUT, compare all outputs.
  task automatic step();
    bit idle, acc, wa, cw, ben, exp_busy, exp_done;
    int aa, ba;
    if (reset) begin
      m_clr      = -1;
      m_ack_prev = 1'b0;
      m_accepted = 1'b0;
      m_a_dout   = '0;
      m_b_dout   = '0;
      tick();
      check("rst_a_ack",    bus.a_ack,    0);
      check("rst_a_dout",   bus.a_dout,   0);
      check("rst_b_valid",  bus.b_valid,  0);
      check("rst_b_dout",   bus.b_dout,   0);
      check("rst_clr_busy", bus.clr_busy, 0);
      check("rst_clr_done", bus.clr_done, 0);
      return;
    end
    aa   = int'(bus.a_addr);
    ba   = int'(bus.b_addr);
    ben  = bus.b_en;
    idle = (m_clr < 0);
    acc  = bus.a_req && idle && !bus.clr_start && !m_ack_prev;
    wa   = acc && bus.a_we && (aa < DEPTH);
    cw   = (m_clr >= 0) && (m_clr < DEPTH);
    if (ben) begin
      if (ba >= DEPTH)                   m_b_dout = '0;
      else if (BYP && wa && aa == ba)    m_b_dout = bus.a_din;
      else if (BYP && cw && m_clr == ba) m_b_dout = FILL;
      else                               m_b_dout = m_mem[ba];
    end
    if (acc && !bus.a_we) m_a_dout = (aa < DEPTH) ? m_mem[aa] : 8'h00;
    if (wa) m_mem[aa] = bus.a_din;
    if (cw) m_mem[m_clr] = FILL;
    if (idle && bus.clr_start)            m_clr = 0;
    else if (m_clr >= 0 && m_clr < DEPTH) m_clr++;
    else                                  m_clr = -1;
    m_ack_prev = acc;
    m_accepted = acc;
    exp_busy   = (m_clr >= 0) && (m_clr < DEPTH);
    exp_done   = (m_clr == DEPTH);
    tick();
    check("a_ack",    bus.a_ack,    acc);
    check("a_dout",   bus.a_dout,   m_a_dout);
    check("b_valid",  bus.b_valid,  ben);
    check("b_dout",   bus.b_dout,   m_b_dout);
    check("clr_busy", bus.clr_busy, exp_busy);
    check("clr_done", bus.clr_done, exp_done);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(3))
      0:       return AW'(32'h100 + $urandom_range(3));
      1:       return AW'($urandom_range(DEPTH - 1));
      2:       return AW'(DEPTH + $urandom_range((1 << AW) - 1 - DEPTH));
      default: return ($urandom_range(1) == 0) ? AW'(0) : AW'(DEPTH - 1);
    endcase
  endfunction

  // Port A transaction from a non-ack cycle; ack must follow the very next edge.
  task automatic a_op(input bit we, input logic [AW-1:0] addr, input logic [7:0] din,
                      output logic [7:0] dout);
    bus.a_req  = 1'b1;
    bus.a_we   = we;
    bus.a_addr = addr;
    bus.a_din  = din;
    step();
    check("a_ack_latency", bus.a_ack, 1);
    dout       = bus.a_dout;
    bus.a_req  = 1'b0;
    step();
  endtask

  // Run one clear to completion; optionally inject a restart pulse, B traffic
  // and a port A write mid-clear. Returns busy/done counts and ack wait.
  task automatic run_clear(input bit b_traffic, input int restart_at, input int a_at,
                           input logic [AW-1:0] a_adr, input logic [7:0] a_dat,
                           output int busy_cnt, output int done_cnt, output int ack_wait);
    int guard;
    busy_cnt = 0;
    done_cnt = 0;
    ack_wait = -1;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    busy_cnt += int'(bus.clr_busy);
    guard = 0;
    while (m_clr >= 0 && guard < 3 * DEPTH) begin
      bus.clr_start = (busy_cnt == restart_at);
      if (busy_cnt == a_at) begin
        bus.a_req  = 1'b1;
        bus.a_we   = 1'b1;
        bus.a_addr = a_adr;
        bus.a_din  = a_dat;
      end
      if (b_traffic) begin
        bus.b_en   = $urandom_range(1);
        bus.b_addr = ($urandom_range(2) == 0 && m_clr < DEPTH) ? AW'(m_clr) : rand_addr();
      end
      step();
      busy_cnt += int'(bus.clr_busy);
      done_cnt += int'(bus.clr_done);
      guard++;
    end
    bus.clr_start = 1'b0;
    bus.b_en      = 1'b0;
    check("clr_terminates", (m_clr < 0), 1);
    // A request held through the clear is taken on the first IDLE cycle.
    for (int i = 1; i <= 4 && bus.a_req; i++) begin
      step();
      if (m_accepted) begin
        ack_wait  = i;
        bus.a_req = 1'b0;
      end
    end
    step();
  endtask

  logic [7:0] rd;
  int busy_cnt, done_cnt, ack_wait, acks, b2b;
  bit prev_ack;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    reset         = 1'b1;
    bus.a_req     = 1'b0;
    bus.a_we      = 1'b0;
    bus.a_addr    = '0;
    bus.a_din     = '0;
    bus.b_en      = 1'b0;
    bus.b_addr    = '0;
    bus.clr_start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Clear with a simultaneous write request (clear wins) and an ignored restart.
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b1;
    bus.a_addr = AW'(16'h0123);
    bus.a_din  = 8'h33;
    run_clear(1'b0, 3000, -1, '0, '0, busy_cnt, done_cnt, ack_wait);
    check("clr1_busy_len", busy_cnt, DEPTH);
    check("clr1_done_cnt", done_cnt, 1);
    check("clr1_a_wait",   ack_wait, 1);
    a_op(1'b0, AW'(16'h0123), 8'h00, rd);
    check("clr1_a_landed", rd, 8'h33);

    // Basic port A write/read, out-of-range behaviour.
    a_op(1'b1, AW'(16'h0100), 8'h5A, rd);
    a_op(1'b0, AW'(16'h0100), 8'h00, rd);
    check("a_rd_0100", rd, 8'h5A);
    a_op(1'b1, AW'(DEPTH + 5), 8'hEE, rd);
    a_op(1'b0, AW'(DEPTH + 5), 8'h00, rd);
    check("a_rd_oor", rd, 8'h00);
    a_op(1'b0, AW'(0), 8'h00, rd);
    check("a_rd_fill", rd, FILL);

    // Port B streaming reads, in range and out of range.
    bus.b_en   = 1'b1;
    bus.b_addr = AW'(16'h0100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b_valid_0100", bus.b_valid, 1);
      check("b_dout_0100",  bus.b_dout,  8'h5A);
    end
    bus.b_addr = AW'(DEPTH);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b_dout_oor", bus.b_dout, 8'h00);
    end
    bus.b_en = 1'b0;
    step();
    check("b_valid_off", bus.b_valid, 0);
    check("b_dout_hold", bus.b_dout,  8'h00);

    // Same-edge port A write and port B read of one address.
    a_op(1'b1, AW'(0), 8'h22, rd);
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b1;
    bus.a_addr = AW'(0);
    bus.a_din  = 8'h11;
    bus.b_en   = 1'b1;
    bus.b_addr = AW'(0);
    step();
    check("collide_b", bus.b_dout, BYP ? 8'h11 : 8'h22);
    bus.a_req = 1'b0;
    bus.b_en  = 1'b0;
    step();

    // Randomized traffic on both ports.
    for (int n = 0; n < 1500; n++) begin
      if (!bus.a_req && $urandom_range(2) == 0) begin
        bus.a_req  = 1'b1;
        bus.a_we   = $urandom_range(1);
        bus.a_addr = rand_addr();
        bus.a_din  = 8'($urandom);
      end
      bus.b_en   = ($urandom_range(3) != 0);
      bus.b_addr = ($urandom_range(2) == 0) ? bus.a_addr : rand_addr();
      step();
      if (m_accepted) bus.a_req = 1'b0;
    end
    bus.a_req = 1'b0;
    bus.b_en  = 1'b0;
    step();
    step();

    // Held read request for four cycles: two acceptances, never adjacent acks.
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b0;
    bus.a_addr = AW'(16'h0100);
    acks       = 0;
    b2b        = 0;
    prev_ack   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.a_ack === 1'b1) begin
        acks++;
        if (prev_ack) b2b++;
      end
      prev_ack = (bus.a_ack === 1'b1);
    end
    bus.a_req = 1'b0;
    step();
    check("held_acks",  acks, 2);
    check("held_b2b",   b2b,  0);

    // Second clear with B traffic and a write issued mid-clear.
    run_clear(1'b1, 4000, 500, AW'(16'h0200), 8'h9C, busy_cnt, done_cnt, ack_wait);
    check("clr2_busy_len", busy_cnt, DEPTH);
    check("clr2_done_cnt", done_cnt, 1);
    check("clr2_a_wait",   ack_wait, 1);
    bus.b_en   = 1'b1;
    bus.b_addr = AW'(0);
    step();
    check("clr2_b_0000", bus.b_dout, FILL);
    bus.b_addr = AW'(16'h17FF);
    step();
    check("clr2_b_17ff", bus.b_dout, FILL);
    bus.b_addr = AW'(16'h0200);
    step();
    check("clr2_b_0200", bus.b_dout, 8'h9C);
    bus.b_en = 1'b0;
    step();

    // Reset at clear cycle 100 aborts the fill.
    a_op(1'b1, AW'(99),  8'h77, rd);
    a_op(1'b1, AW'(100), 8'h77, rd);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    while (m_clr < 100) step();
    reset = 1'b1;
    step();
    check("abort_busy", bus.clr_busy, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      done_cnt += int'(bus.clr_done === 1'b1);
    end
    check("abort_no_done", done_cnt, 0);
    bus.b_en   = 1'b1;
    bus.b_addr = AW'(99);
    step();
    check("abort_b_99", bus.b_dout, FILL);
    bus.b_addr = AW'(100);
    step();
    check("abort_b_100", bus.b_dout, 8'h77);
    bus.b_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the whole run is a few tens of thousands of cycles.
  initial begin
    #2ms;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_vid_ram_gen
